// File: rtl/ir_receive.sv
// ir_receive: NEC infrared remote decoder.
//
// The demodulated receiver output (iIRDA, low while a carrier burst is
// present) goes through a two-flop synchronizer. The leader (long low, then
// long high) is measured first. After that, every data bit is a short burst
// followed by a high period. The length of the high period gives the bit
// value. After 32 bits the frame is published on oDATA, and oDATA_READY
// pulses for one cycle.
//
// Ports:
//   iCLK         in   system clock, rising edge
//   iRST_n       in   asynchronous active-low reset
//   iIRDA        in   receiver output, low = burst
//   oDATA_READY  out  one-cycle strobe when a valid frame is latched
//   oDATA[31:0]  out  last valid frame, first received bit in bit 0
//   oSTATE[1:0]  out  debug view of the decoder state (0 idle, 1 guidance,
//                     2 data read)
//
// Parameters are pulse-width thresholds in iCLK cycles (defaults: 50 MHz).
//
// Build option: define IR_FRAME_CHECK_EN to accept only frames whose byte 3
// is the bitwise inverse of byte 2 (the key code). Without it, every complete
// 32-bit frame is accepted.
//
// Handshake: oDATA_READY is a single-cycle valid with no ready. oDATA stays
// stable until the next accepted frame.

module ir_receive #(
  parameter int unsigned GUIDE_LOW_DUR  = 230000,
  parameter int unsigned GUIDE_HIGH_DUR = 210000,
  parameter int unsigned DATA_HIGH_DUR  = 41500,
  parameter int unsigned IDLE_HIGH_DUR  = 262143
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic        iIRDA,
  output logic        oDATA_READY,
  output logic [31:0] oDATA,
  output logic [1:0]  oSTATE
);

  localparam logic [17:0] GUIDE_LOW_C  = 18'(GUIDE_LOW_DUR);
  localparam logic [17:0] GUIDE_HIGH_C = 18'(GUIDE_HIGH_DUR);
  localparam logic [17:0] DATA_HIGH_C  = 18'(DATA_HIGH_DUR);
  localparam logic [17:0] IDLE_HIGH_C  = 18'(IDLE_HIGH_DUR);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GUIDANCE = 2'd1,
    DATAREAD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        sync1_q, sync2_q, prev_q;
  logic [17:0] low_cnt_q, low_cnt_d;
  logic [17:0] high_cnt_q, high_cnt_d;
  logic [4:0]  idx_q, idx_d;
  logic        started_q, started_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] data_q, data_d;
  logic        ready_q, ready_d;

  logic        rise, fall, bit_val, frame_ok;
  logic [31:0] frame_next;

  function automatic logic [17:0] sat_inc(input logic [17:0] c);
    sat_inc = (c == 18'h3ffff) ? c : c + 18'd1;
  endfunction

  assign rise = sync2_q & ~prev_q;
  assign fall = ~sync2_q & prev_q;

  always_comb begin
    state_d    = state_q;
    low_cnt_d  = low_cnt_q;
    high_cnt_d = high_cnt_q;
    idx_d      = idx_q;
    started_d  = started_q;
    buf_d      = buf_q;
    data_d     = data_q;
    ready_d    = 1'b0;
    bit_val    = (high_cnt_q > DATA_HIGH_C);
    frame_next = buf_q;
    frame_next[idx_q] = bit_val;
`ifdef IR_FRAME_CHECK_EN
    frame_ok   = (frame_next[31:24] == ~frame_next[23:16]);
`else
    frame_ok   = 1'b1;
`endif

    case (state_q)
      IDLE: begin
        if (sync2_q) begin
          low_cnt_d = '0;
        end else begin
          low_cnt_d = sat_inc(low_cnt_q);
          if (low_cnt_q > GUIDE_LOW_C) begin
            state_d    = GUIDANCE;
            high_cnt_d = '0;
          end
        end
      end

      GUIDANCE: begin
        // A high period that ends too early is a repeat code or noise.
        if (fall) begin
          state_d   = IDLE;
          low_cnt_d = '0;
        end else if (sync2_q) begin
          high_cnt_d = sat_inc(high_cnt_q);
          if (high_cnt_q > GUIDE_HIGH_C) begin
            state_d    = DATAREAD;
            idx_d      = '0;
            buf_d      = '0;
            started_d  = 1'b0;
            high_cnt_d = '0;
          end
        end
      end

      DATAREAD: begin
        if (rise) begin
          high_cnt_d = '0;
          started_d  = 1'b1;
        end else if (sync2_q) begin
          high_cnt_d = sat_inc(high_cnt_q);
          // The counter saturates at its maximum value. Reaching the limit
          // is therefore the abort condition, so a limit equal to that
          // maximum still takes effect.
          if (high_cnt_q >= IDLE_HIGH_C) begin
            state_d   = IDLE;
            low_cnt_d = '0;
          end
        end

        // The falling edge that ends the remaining leader high period has no
        // measured bit in front of it. The started flag skips that edge.
        if (fall && started_q) begin
          buf_d     = frame_next;
          idx_d     = idx_q + 5'd1;
          started_d = 1'b0;
          if (idx_q == 5'd31) begin
            state_d   = IDLE;
            low_cnt_d = '0;
            if (frame_ok) begin
              data_d  = frame_next;
              ready_d = 1'b1;
            end
          end
        end
      end

      default: begin
        state_d   = IDLE;
        low_cnt_d = '0;
      end
    endcase
  end

  // The synchronizer resets to 1 (line idle). This prevents a false falling
  // edge right after reset.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      state_q    <= IDLE;
      low_cnt_q  <= '0;
      high_cnt_q <= '0;
      idx_q      <= '0;
      started_q  <= 1'b0;
      buf_q      <= '0;
      data_q     <= '0;
      ready_q    <= 1'b0;
    end else begin
      sync1_q    <= iIRDA;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      state_q    <= state_d;
      low_cnt_q  <= low_cnt_d;
      high_cnt_q <= high_cnt_d;
      idx_q      <= idx_d;
      started_q  <= started_d;
      buf_q      <= buf_d;
      data_q     <= data_d;
      ready_q    <= ready_d;
    end
  end

  assign oDATA_READY = ready_q;
  assign oDATA       = data_q;
  assign oSTATE      = state_q;

endmodule

// File: tb/tb_ir_receive.sv
// Testbench for ir_receive. The pulse-width thresholds are scaled down so
// that whole NEC frames finish in a few thousand cycles.
// Scaled timing (in cycles):
//   leader low 180, leader high 90, burst 11
//   bit-0 high 11, bit-1 high 34, repeat-code high 45
// Expected frames go into a queue together with the cycle in which the
// strobe should appear. A monitor pops the queue on every strobe.

module tb_ir_receive;

  localparam int LDR_LO = 180;
  localparam int LDR_HI = 90;
  localparam int BURST  = 11;
  localparam int HI0    = 11;
  localparam int HI1    = 34;

  logic        iCLK;
  logic        iRST_n;
  logic        iIRDA;
  logic        oDATA_READY;
  logic [31:0] oDATA;
  logic [1:0]  oSTATE;

  logic [31:0] exp_q[$];
  int          cyc_q[$];
  logic [31:0] last_data;
  int          cyc;
  int          n_vec;
  int          n_err;

  ir_receive #(
    .GUIDE_LOW_DUR (90),
    .GUIDE_HIGH_DUR(60),
    .DATA_HIGH_DUR (16),
    .IDLE_HIGH_DUR (120)
  ) dut (
    .iCLK       (iCLK),
    .iRST_n     (iRST_n),
    .iIRDA      (iIRDA),
    .oDATA_READY(oDATA_READY),
    .oDATA      (oDATA),
    .oSTATE     (oSTATE)
  );

  // Clock and cycle counter
  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  initial cyc = 0;
  always @(posedge iCLK) cyc = cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit frame_valid(input logic [31:0] d);
`ifdef IR_FRAME_CHECK_EN
    frame_valid = (d[31:24] == ~d[23:16]);
`else
    frame_valid = 1'b1;
`endif
  endfunction

  // Driver tasks. Each one is entered at a falling clock edge and returns at
  // a falling clock edge.
  task automatic hold(input logic v, input int n);
    iIRDA = v;
    repeat (n) @(negedge iCLK);
  endtask

  task automatic leader();
    hold(1'b0, LDR_LO);
    hold(1'b1, LDR_HI);
  endtask

  task automatic send_bits(input logic [31:0] d, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      hold(1'b0, BURST);
      hold(1'b1, d[i] ? HI1 : HI0);
    end
  endtask

  // Stop burst. A strobe is expected 3 cycles after the fall.
  task automatic stop_burst(input logic [31:0] d, input bit in_frame);
    if (in_frame && frame_valid(d)) begin
      exp_q.push_back(d);
      cyc_q.push_back(cyc + 3);
      last_data = d;
    end
    hold(1'b0, BURST);
    hold(1'b1, 30);
  endtask

  task automatic send_frame(input logic [31:0] d);
    leader();
    send_bits(d, 0, 31);
    stop_burst(d, 1'b1);
  endtask

  // Scoreboard monitor: samples 1 time unit after each rising edge
  always @(posedge iCLK) begin
    logic [31:0] e;
    int          ec;
    #1;
    if (iRST_n && oDATA_READY) begin
      if (exp_q.size() == 0) begin
        check("spurious_strobe", 32'd1, 32'd0);
      end else begin
        e  = exp_q.pop_front();
        ec = cyc_q.pop_front();
        check("frame_data", oDATA, e);
        check("strobe_latency", 32'(cyc), 32'(ec));
      end
    end
  end

  initial begin
    logic [31:0] d;
    logic [7:0]  key, addr;
    n_vec     = 0;
    n_err     = 0;
    last_data = '0;
    iIRDA     = 1'b1;
    iRST_n    = 1'b0;
    repeat (4) @(negedge iCLK);
    #1;
    check("rst_data", oDATA, 32'h0);
    check("rst_ready", {31'd0, oDATA_READY}, 32'h0);
    check("rst_state", {30'd0, oSTATE}, 32'h0);
    @(negedge iCLK);
    iRST_n = 1'b1;
    hold(1'b1, 20);

    // Nominal frame
    send_frame(32'hED12FF00);
    check("frame1_hold", oDATA, 32'hED12FF00);

    // Byte 3 not the inverse of the key
    send_frame(32'h0012FF00);
    check("bad_inv_data", oDATA, last_data);

    // Repeat code: leader high too short
    hold(1'b0, LDR_LO);
    hold(1'b1, 45);
    hold(1'b0, BURST);
    hold(1'b1, 30);
    check("repeat_state", {30'd0, oSTATE}, 32'h0);
    check("repeat_data", oDATA, last_data);

    // Low pulse shorter than the leader
    hold(1'b0, 80);
    check("short_low_state", {30'd0, oSTATE}, 32'h0);
    hold(1'b1, 20);
    check("short_low_after", {30'd0, oSTATE}, 32'h0);

    // Truncated frame: 10 bits, then a long high period
    leader();
    send_bits(32'hA5A5A5A5, 0, 9);
    check("trunc_in_data", {30'd0, oSTATE}, 32'h2);
    hold(1'b1, 240);
    check("trunc_state", {30'd0, oSTATE}, 32'h0);
    check("trunc_data", oDATA, last_data);
    send_frame({~8'h1A, 8'h1A, 8'hFF, 8'h00});
    check("key_1a", {24'd0, oDATA[23:16]}, 32'h1A);

    // Random frames. Some have a random byte 3.
    for (int n = 0; n < 4; n++) begin
      key  = 8'($urandom_range(0, 255));
      addr = 8'($urandom_range(0, 255));
      d    = {~key, key, ~addr, addr};
      if (n[0]) d[31:24] = 8'($urandom_range(0, 255));
      send_frame(d);
      check("rand_hold", oDATA, last_data);
    end

    // Reset in the middle of the data phase
    leader();
    send_bits(32'h7E81C33C, 0, 11);
    iRST_n = 1'b0;
    #1;
    check("midrst_data", oDATA, 32'h0);
    check("midrst_ready", {31'd0, oDATA_READY}, 32'h0);
    check("midrst_state", {30'd0, oSTATE}, 32'h0);
    last_data = '0;
    repeat (3) @(negedge iCLK);
    iRST_n = 1'b1;
    send_bits(32'h7E81C33C, 12, 31);
    stop_burst(32'h7E81C33C, 1'b0);
    check("post_rst_data", oDATA, 32'h0);

    // The decoder works again after the reset
    send_frame(32'hB54AEF10);
    check("recover_data", oDATA, last_data);

    repeat (20) @(negedge iCLK);
    check("leftover_expected", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time limit in case a driver task never returns
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
